// File: rtl/heat_stencil_engine_pkg.sv
// Shared types and helpers for the heat stencil engine.
// Optional feature macro used by the engine: HEAT_CONV_EN (early exit on convergence).
package heat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] BND_DIRICHLET = 2'b00;
    localparam logic [1:0] BND_NEUMANN   = 2'b01;
    localparam logic [1:0] BND_PERIODIC  = 2'b10;

    // Saturate a signed value into the unsigned range [0, 2^dw-1].
    function automatic logic [63:0] clamp_u(input logic signed [63:0] v, input int unsigned dw);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< dw) - 64'sd1;
        if (v < 64'sd0) begin
            return 64'd0;
        end else if (v > hi) begin
            return hi;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/heat_stencil_engine_pe.sv
// Combinational 5-point Jacobi update for one cell, including the
// Dirichlet edge override. Neighbour selection is done by the caller.
module heat_stencil_pe
    import heat_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic [DW-1:0] tc,
    input  logic [DW-1:0] tl,
    input  logic [DW-1:0] tr,
    input  logic [DW-1:0] tu,
    input  logic [DW-1:0] td,
    input  logic [AW-1:0] alpha,
    input  logic [DW-1:0] bnd_temp,
    input  logic          edge_cell,
    input  logic [1:0]    mode,
    output logic [DW-1:0] tn
);

    localparam int LW = DW + 4;
    localparam int PW = LW + AW + 1;

    logic signed [LW-1:0] lap_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] upd_s;
    logic signed [PW-1:0] sum_s;
    logic        [DW-1:0] tn_calc_s;

    // Laplacian, scaled by alpha/2^(AW+2) with floor, added to Tc and saturated.
    always_comb begin
        lap_s = $signed({4'b0000, tl}) + $signed({4'b0000, tr})
              + $signed({4'b0000, tu}) + $signed({4'b0000, td})
              - $signed({2'b00, tc, 2'b00});
        prod_s = $signed({{(AW + 1){lap_s[LW-1]}}, lap_s})
               * $signed({{(LW + 1){1'b0}}, alpha});
        upd_s = prod_s >>> (AW + 2);
        sum_s = $signed({{(PW - DW){1'b0}}, tc}) + upd_s;
        tn_calc_s = DW'(clamp_u(64'(sum_s), DW));
        if ((mode == BND_DIRICHLET) && edge_cell) begin
            tn = bnd_temp;
        end else begin
            tn = tn_calc_s;
        end
    end

endmodule

// File: rtl/heat_stencil_engine.sv
// Jacobi 5-point heat stencil engine with ping-pong grid banks and a
// run-for-N-sweeps controller. Optional macro HEAT_CONV_EN adds an early
// exit once the largest per-sweep cell change is within cfg_eps.
module heat_stencil_engine
    import heat_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int IW     = 16,
    parameter int ADDR_W = $clog2(GRID_W * GRID_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [IW-1:0]     num_iter,
    input  logic [AW-1:0]     cfg_alpha,
    input  logic [DW-1:0]     cfg_bnd_temp,
    input  logic [1:0]        cfg_bnd_mode,
`ifdef HEAT_CONV_EN
    input  logic [DW-1:0]     cfg_eps,
    output logic              converged,
`endif
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              busy,
    output logic              done,
    output logic [IW-1:0]     iter_count
);

    localparam int NCELL = GRID_W * GRID_H;
    localparam int XW    = $clog2(GRID_W);
    localparam int YW    = $clog2(GRID_H);

    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NCELL - 1);
    localparam logic [IW-1:0]     ITER_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0]     ITER_ONE  = {{(IW - 1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]     X_ZERO = {XW{1'b0}};
    localparam logic [XW-1:0]     X_ONE  = {{(XW - 1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]     X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0]     Y_ZERO = {YW{1'b0}};
    localparam logic [YW-1:0]     Y_ONE  = {{(YW - 1){1'b0}}, 1'b1};
    localparam logic [YW-1:0]     Y_LAST = YW'(GRID_H - 1);

    // Grid storage: live_q selects the bank holding the last completed sweep.
    logic [DW-1:0] bank0_q [NCELL];
    logic [DW-1:0] bank1_q [NCELL];

    state_e            state_q, state_d;
    logic              live_q, live_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [IW-1:0]     num_iter_q, num_iter_d;
    logic [AW-1:0]     alpha_q, alpha_d;
    logic [DW-1:0]     bnd_temp_q, bnd_temp_d;
    logic [1:0]        bnd_mode_q, bnd_mode_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wr_ready_q, wr_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;

    logic [XW-1:0]     cell_x_s;
    logic [YW-1:0]     cell_y_s;
    logic              at_l_s, at_r_s, at_u_s, at_d_s, edge_s, neumann_s;
    logic [ADDR_W-1:0] addr_l_s, addr_r_s, addr_u_s, addr_d_s;
    logic [DW-1:0]     tc_s, tl_s, tr_s, tu_s, td_s, tn_s, host_rd_s;
    logic [IW-1:0]     iter_inc_s;
    logic              conv_hit_s;
    logic              host_we_s, run_we_s, we0_s, we1_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DW-1:0]     wdata_s;

`ifdef HEAT_CONV_EN
    logic [DW-1:0] eps_q, eps_d;
    logic [DW-1:0] max_q, max_d;
    logic          converged_q, converged_d;
    logic [DW-1:0] diff_s, sweep_max_s;
`endif

    // Neighbour addresses: wrap naturally (periodic), fold onto the centre for Neumann edges.
    always_comb begin
        cell_x_s  = idx_q[XW-1:0];
        cell_y_s  = idx_q[ADDR_W-1:XW];
        at_l_s    = (cell_x_s == X_ZERO);
        at_r_s    = (cell_x_s == X_LAST);
        at_u_s    = (cell_y_s == Y_ZERO);
        at_d_s    = (cell_y_s == Y_LAST);
        edge_s    = at_l_s | at_r_s | at_u_s | at_d_s;
        neumann_s = (bnd_mode_q == BND_NEUMANN) || (bnd_mode_q == 2'b11);
        if (neumann_s && at_l_s) addr_l_s = idx_q; else addr_l_s = {cell_y_s, cell_x_s - X_ONE};
        if (neumann_s && at_r_s) addr_r_s = idx_q; else addr_r_s = {cell_y_s, cell_x_s + X_ONE};
        if (neumann_s && at_u_s) addr_u_s = idx_q; else addr_u_s = {cell_y_s - Y_ONE, cell_x_s};
        if (neumann_s && at_d_s) addr_d_s = idx_q; else addr_d_s = {cell_y_s + Y_ONE, cell_x_s};
    end

    // All stencil and host reads come from the live bank.
    always_comb begin
        if (live_q) begin
            tc_s      = bank1_q[idx_q];
            tl_s      = bank1_q[addr_l_s];
            tr_s      = bank1_q[addr_r_s];
            tu_s      = bank1_q[addr_u_s];
            td_s      = bank1_q[addr_d_s];
            host_rd_s = bank1_q[rd_addr];
        end else begin
            tc_s      = bank0_q[idx_q];
            tl_s      = bank0_q[addr_l_s];
            tr_s      = bank0_q[addr_r_s];
            tu_s      = bank0_q[addr_u_s];
            td_s      = bank0_q[addr_d_s];
            host_rd_s = bank0_q[rd_addr];
        end
    end

    heat_stencil_pe #(
        .DW (DW),
        .AW (AW)
    ) u_pe (
        .tc        (tc_s),
        .tl        (tl_s),
        .tr        (tr_s),
        .tu        (tu_s),
        .td        (td_s),
        .alpha     (alpha_q),
        .bnd_temp  (bnd_temp_q),
        .edge_cell (edge_s),
        .mode      (bnd_mode_q),
        .tn        (tn_s)
    );

`ifdef HEAT_CONV_EN
    // Largest |Tn-Tc| seen so far in this sweep, including the current cell.
    always_comb begin
        if (tn_s >= tc_s) begin
            diff_s = tn_s - tc_s;
        end else begin
            diff_s = tc_s - tn_s;
        end
        if (diff_s > max_q) begin
            sweep_max_s = diff_s;
        end else begin
            sweep_max_s = max_q;
        end
        conv_hit_s = (sweep_max_s <= eps_q);
    end
`else
    // Without convergence tracking the run always uses every requested sweep.
    always_comb begin
        conv_hit_s = 1'b0;
    end
`endif

    // Bank write steering: host writes the live bank in IDLE, the sweep writes the other one.
    always_comb begin
        host_we_s = wr_valid && wr_ready_q;
        run_we_s  = (state_q == RUN);
        we0_s     = (host_we_s && !live_q) || (run_we_s && live_q);
        we1_s     = (host_we_s && live_q) || (run_we_s && !live_q);
        if (host_we_s) begin
            waddr_s = wr_addr;
            wdata_s = wr_data;
        end else begin
            waddr_s = idx_q;
            wdata_s = tn_s;
        end
    end

    // Grid memory write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we0_s) begin
            bank0_q[waddr_s] <= wdata_s;
        end
        if (we1_s) begin
            bank1_q[waddr_s] <= wdata_s;
        end
    end

    // Controller next state: config latch, sweep sequencing, abort and host reads.
    always_comb begin
        state_d    = state_q;
        live_d     = live_q;
        idx_d      = idx_q;
        iter_d     = iter_q;
        num_iter_d = num_iter_q;
        alpha_d    = alpha_q;
        bnd_temp_d = bnd_temp_q;
        bnd_mode_d = bnd_mode_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        iter_inc_s = iter_q + ITER_ONE;
`ifdef HEAT_CONV_EN
        eps_d       = eps_q;
        max_d       = max_q;
        converged_d = converged_q;
`endif
        case (state_q)
            IDLE: begin
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = host_rd_s;
                end else begin
                    rd_valid_d = 1'b0;
                end
                if (start) begin
                    num_iter_d = num_iter;
                    alpha_d    = cfg_alpha;
                    bnd_temp_d = cfg_bnd_temp;
                    bnd_mode_d = cfg_bnd_mode;
                    iter_d     = ITER_ZERO;
                    idx_d      = IDX_ZERO;
`ifdef HEAT_CONV_EN
                    eps_d       = cfg_eps;
                    max_d       = {DW{1'b0}};
                    converged_d = 1'b0;
`endif
                    if (num_iter == ITER_ZERO) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = IDX_ZERO;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        live_d = ~live_q;
                        iter_d = iter_inc_s;
`ifdef HEAT_CONV_EN
                        max_d = {DW{1'b0}};
                        if (conv_hit_s) begin
                            converged_d = 1'b1;
                        end else begin
                            converged_d = converged_q;
                        end
`endif
                        if ((iter_inc_s == num_iter_q) || conv_hit_s) begin
                            state_d = DONE;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
`ifdef HEAT_CONV_EN
                        max_d = sweep_max_s;
`endif
                        state_d = RUN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d     = (state_d == RUN);
        done_d     = (state_d == DONE);
        wr_ready_d = (state_d == IDLE);
    end

    // Controller and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            live_q     <= 1'b0;
            idx_q      <= IDX_ZERO;
            iter_q     <= ITER_ZERO;
            num_iter_q <= ITER_ZERO;
            alpha_q    <= {AW{1'b0}};
            bnd_temp_q <= {DW{1'b0}};
            bnd_mode_q <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= {DW{1'b0}};
`ifdef HEAT_CONV_EN
            eps_q       <= {DW{1'b0}};
            max_q       <= {DW{1'b0}};
            converged_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            idx_q      <= idx_d;
            iter_q     <= iter_d;
            num_iter_q <= num_iter_d;
            alpha_q    <= alpha_d;
            bnd_temp_q <= bnd_temp_d;
            bnd_mode_q <= bnd_mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef HEAT_CONV_EN
            eps_q       <= eps_d;
            max_q       <= max_d;
            converged_q <= converged_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign wr_ready   = wr_ready_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign iter_count = iter_q;
`ifdef HEAT_CONV_EN
    assign converged  = converged_q;
`endif

endmodule

// File: tb/tb_heat_stencil_engine.sv
// Directed bench for heat_stencil_engine on a 4x4 grid (address = y*4+x).
module tb_heat_stencil_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic [15:0] num_iter;
    logic [7:0]  cfg_alpha, cfg_bnd_temp;
    logic [1:0]  cfg_bnd_mode;
    logic        wr_valid, wr_ready;
    logic [3:0]  wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;
    logic        rd_en, rd_valid, busy, done;
    logic [15:0] iter_count;
`ifdef HEAT_CONV_EN
    logic [7:0]  cfg_eps;
    logic        converged;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    int busy_cnt;
    int done_seen;

    always #5 clk = ~clk;

    heat_stencil_engine #(.GRID_W(4), .GRID_H(4), .DW(8), .AW(8), .IW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_iter(num_iter),
        .cfg_alpha(cfg_alpha), .cfg_bnd_temp(cfg_bnd_temp), .cfg_bnd_mode(cfg_bnd_mode),
`ifdef HEAT_CONV_EN
        .cfg_eps(cfg_eps), .converged(converged),
`endif
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .done(done), .iter_count(iter_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        wr_valid = 1'b1;
        wr_addr  = addr[3:0];
        wr_data  = data[7:0];
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic rd_check(input int addr, input int exp, input string tag);
        rd_en   = 1'b1;
        rd_addr = addr[3:0];
        tick();
        rd_en = 1'b0;
        check($sformatf("%s_valid_a%0d", tag, addr), {31'd0, rd_valid}, 32'd1);
        check($sformatf("%s_data_a%0d", tag, addr), {24'd0, rd_data}, exp);
    endtask

    task automatic load_uniform(input int v);
        for (int i = 0; i < 16; i++) wr(i, v);
    endtask

    task automatic load_spot();
        for (int i = 0; i < 16; i++) wr(i, (i == 5) ? 160 : 0);
    endtask

    // Pulse start, then count cycles until done (bounded); busy cycles are tallied.
    task automatic run_engine();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic check_spot_result(input string tag);
        rd_check(5, 120, tag);
        rd_check(6, 10, tag);
        rd_check(9, 10, tag);
        rd_check(10, 0, tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; num_iter = 16'd0;
        cfg_alpha = 8'd0; cfg_bnd_temp = 8'd0; cfg_bnd_mode = 2'b00;
        wr_valid = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; rd_en = 1'b0; rd_addr = 4'd0;
`ifdef HEAT_CONV_EN
        cfg_eps = 8'd0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check("rst_iter", {16'd0, iter_count}, 32'd0);
        check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);

        // Single Dirichlet sweep of a hot spot: Jacobi, not in place
        load_spot();
        num_iter = 16'd1; cfg_alpha = 8'd64; cfg_bnd_temp = 8'd0; cfg_bnd_mode = 2'b00;
        run_engine();
        check("t1_done_cycle", cyc, 32'd17);
        check("t1_busy_cycles", busy_cnt, 32'd16);
        check("t1_iter", {16'd0, iter_count}, 32'd1);
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        check("t1_wr_ready", {31'd0, wr_ready}, 32'd1);
        check_spot_result("t1");
        for (int i = 0; i < 16; i++) begin
            if ((i % 4 == 0) || (i % 4 == 3) || (i < 4) || (i > 11)) rd_check(i, 0, "t1_edge");
        end

        // Periodic uniform field stays put for 5 sweeps
        load_uniform(100);
        num_iter = 16'd5; cfg_bnd_mode = 2'b10;
        run_engine();
        check("t2_done_cycle", cyc, 32'd81);
        check("t2_busy_cycles", busy_cnt, 32'd80);
        check("t2_iter", {16'd0, iter_count}, 32'd5);
        tick();
        for (int i = 0; i < 16; i++) rd_check(i, 100, "t2");

        // Zero sweeps: immediate done, banks untouched
        num_iter = 16'd0;
        run_engine();
        check("t3_done_cycle", cyc, 32'd1);
        check("t3_busy_cycles", busy_cnt, 32'd0);
        check("t3_iter", {16'd0, iter_count}, 32'd0);
        tick();
        rd_check(0, 100, "t3");
        rd_check(5, 100, "t3");

        // Abort mid sweep 2 leaves the single-sweep result
        load_spot();
        num_iter = 16'd3; cfg_bnd_mode = 2'b00; cfg_alpha = 8'd64;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_seen = 0;
        for (int k = 2; k <= 20; k++) begin
            rd_en = (k == 5);
            tick();
            rd_en = 1'b0;
            if (k == 6) check("t4_rd_in_run_ignored", {31'd0, rd_valid}, 32'd0);
            if (done) done_seen++;
        end
        check("t4_busy_before_abort", {31'd0, busy}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy_after_abort", {31'd0, busy}, 32'd0);
        check("t4_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("t4_iter", {16'd0, iter_count}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            if (done) done_seen++;
            tick();
        end
        check("t4_no_done", done_seen, 32'd0);
        check_spot_result("t4");

        // Start and host write during a run are ignored
        load_uniform(100);
        num_iter = 16'd2; cfg_bnd_mode = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            start    = (cyc == 5);
            wr_valid = (cyc == 5);
            wr_addr  = 4'd0;
            wr_data  = 8'd7;
            tick();
            start    = 1'b0;
            wr_valid = 1'b0;
            cyc++;
        end
        check("t5_done_cycle", cyc, 32'd33);
        check("t5_iter", {16'd0, iter_count}, 32'd2);
        tick();
        check("t5_back_idle", {31'd0, busy}, 32'd0);
        rd_check(0, 100, "t5");

        // Reset mid run
        num_iter = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        check("t6_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_iter", {16'd0, iter_count}, 32'd0);
        check("t6_wr_ready", {31'd0, wr_ready}, 32'd1);
        check("t6_done", {31'd0, done}, 32'd0);
        load_uniform(100);
        num_iter = 16'd1;
        run_engine();
        check("t6_rerun_cycle", cyc, 32'd17);
        check("t6_rerun_iter", {16'd0, iter_count}, 32'd1);
        tick();
        rd_check(3, 100, "t6");

`ifdef HEAT_CONV_EN
        // Uniform Neumann field converges after one sweep
        load_uniform(50);
        num_iter = 16'd10; cfg_bnd_mode = 2'b01; cfg_eps = 8'd0;
        run_engine();
        check("t7_done_cycle", cyc, 32'd17);
        check("t7_iter", {16'd0, iter_count}, 32'd1);
        check("t7_converged", {31'd0, converged}, 32'd1);
        tick();
        rd_check(0, 50, "t7");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/heat_stencil_engine.md
Name: heat_stencil_engine

Overview:
Parametrised successor to the 16x16 in-place heat solver. It is a Jacobi 5-point stencil engine with two ping-pong grid banks, configurable grid, data and coefficient widths, and a run-for-N-iterations FSM with a done pulse. Abort returns the engine to the last completed sweep intact. It sits behind the tile's pin-mux/control decoder, which drives the host port.

Parameters:
GRID_W, 16, grid width in cells (power of two, >=4)
GRID_H, 16, grid height in cells (power of two, >=4)
DW, 8, temperature width, unsigned
AW, 8, alpha width; effective coefficient = alpha/2^(AW+2)
IW, 16, iteration counter width
ADDR_W, log2(GRID_W*GRID_H), derived; address = {y, x}

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  begin run; accepted only in IDLE
abort  in  1  stop run; honoured only in RUN
num_iter  in  IW  sweeps to perform, sampled at start
cfg_alpha  in  AW  diffusion coefficient, sampled at start
cfg_bnd_temp  in  DW  Dirichlet boundary value, sampled at start
cfg_bnd_mode  in  2  00 Dirichlet, 01 Neumann, 10 periodic, 11 = Neumann
wr_valid  in  1  host write strobe
wr_ready  out  1  =1 in IDLE only
wr_addr  in  ADDR_W  host write address
wr_data  in  DW  host write data
rd_en  in  1  host read request, IDLE only
rd_addr  in  ADDR_W  host read address
rd_valid  out  1  read data valid
rd_data  out  DW  read data
busy  out  1  high in RUN
done  out  1  one-cycle pulse at run end
iter_count  out  IW  completed sweeps of current/last run

Behaviour:
- Reset: FSM=IDLE; live bank=0; busy, done, rd_valid=0; rd_data=0; iter_count=0; cell index=0. Grid memories are not cleared.
- States:
  - IDLE: start=1 -> RUN, iter_count=0, config latched. If num_iter=0, go -> DONE instead; no sweep, banks untouched.
  - RUN: each cycle processes one cell, reading the live bank and writing the other bank, index 0..N-1 (N=GRID_W*GRID_H). After cell N-1, live bank toggles and iter_count increments. If iter_count+1==num_iter -> DONE; else continue at cell 0 next cycle with no bubble.
  - DONE: done=1 for one cycle -> IDLE.
- Timing: start at cycle t gives busy on t+1..t+K*N and done at t+K*N+1.
- Abort in RUN: -> IDLE next cycle, no done pulse. Live bank and iter_count keep their last completed-sweep values, and the partial destination bank is discarded.
- start while not IDLE is ignored.
- Host access (IDLE only) targets the live bank.
  - Write commits at the clock edge when wr_valid & wr_ready. wr_valid outside IDLE is dropped.
  - Read: rd_en in IDLE gives rd_valid=1 and rd_data next cycle. rd_en outside IDLE is ignored.
  - wr_valid and start in the same IDLE cycle: the write commits first, and the sweep sees the written data.
- Stencil:
  - lap = Tl+Tr+Tu+Td-4Tc, signed DW+4 bits.
  - upd = (lap*alpha) >>> (AW+2), arithmetic shift (floor).
  - Tn = Tc+upd, clamped to [0, 2^DW-1].
- Boundary neighbours:
  - Neumann: an out-of-grid neighbour equals Tc.
  - Periodic: coordinates wrap modulo GRID_W/GRID_H.
  - Dirichlet: edge cells are written cfg_bnd_temp; interior cells use the normal stencil.
- Reset mid-run: immediate IDLE, outputs per reset, grid contents undefined.

Optional Feature:
HEAT_CONV_EN.
- Defined: adds input cfg_eps (DW, sampled at start) and output converged (1).
  - Per sweep, the engine tracks max |Tn-Tc|.
  - At sweep end, if max <= cfg_eps, the run ends early: DONE with converged=1 held until next start.
  - converged resets to 0.
- Undefined: no port, no tracking; the run always executes num_iter sweeps.

Decomposition:
- Package heat_pkg: FSM state enum (IDLE, RUN, DONE), boundary-mode localparams (BND_DIRICHLET, BND_NEUMANN, BND_PERIODIC), clamp function.
- Sub-module heat_stencil_pe: combinational datapath (Tc, Tl, Tr, Tu, Td, alpha, bnd_temp, edge flag, mode -> Tn). Neighbour address generation stays in the top.

Test Plan:
- 4x4 grid, Dirichlet, bnd=0, alpha=64, all 0 except cell(1,1)=160, num_iter=1. Required after the run: (1,1)=120, (2,1)=10, (1,2)=10, (2,2)=0, edges=0, iter_count=1. This proves Jacobi, not in-place.
- 4x4 grid, periodic, all cells 100, num_iter=5. Required: done at start+81 cycles, all cells 100, iter_count=5.
- num_iter=0. Required: done pulse on cycle t+1, busy never high, readback unchanged.
- num_iter=3, abort 20 cycles after start (mid sweep 2). Required: IDLE next cycle, no done, iter_count=1, readback equals single-sweep result.
- rst pulse mid-run. Required: busy=0, iter_count=0, wr_ready=1 next cycle; start while busy is ignored (iter_count sequence unaffected).
- With HEAT_CONV_EN: uniform grid 50, Neumann, cfg_eps=0, num_iter=10. Required: done after 1 sweep, converged=1, iter_count=1.
